// File: rtl/memctrl_host_pkg.sv
// Shared types and constants for the MEMCTRL bus-side initiator.
package memctrl_host_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_WAIT,
        WR_STB,
        RD_STB,
        RECOV,
        HOLD
    } state_e;

    // Strobe levels while no access is in flight
    localparam logic CE_IDLE  = 1'b0;
    localparam logic CSB_IDLE = 1'b1;
    localparam logic WEB_IDLE = 1'b1;
    localparam logic OEB_IDLE = 1'b1;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 2;

    function automatic bit rd_lat_legal(input int unsigned lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/memctrl_host.sv
// Burst command initiator for MEMCTRL: one strobe per beat, read capture,
// and back-off between beats while MEMCTRL runs BIST.
module memctrl_host
    import memctrl_host_pkg::*;
#(
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned AW     = 16,
    parameter int unsigned DW     = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ_VALID,
    output logic          REQ_READY,
    input  logic          REQ_WE,
    input  logic [AW-1:0] REQ_ADDR,
    input  logic [7:0]    REQ_LEN,
    input  logic          WD_VALID,
    output logic          WD_READY,
    input  logic [DW-1:0] WD_DATA,
    output logic          RD_VALID,
    output logic [DW-1:0] RD_DATA,
    output logic          DONE,
    input  logic          BIST_BUSY,
    output logic          CE,
    output logic          CSB,
    output logic          WEB,
    output logic          OEB,
    output logic [AW-1:0] ADDR,
    output logic [DW-1:0] IDATA,
    input  logic [DW-1:0] ODATA
);

    localparam int unsigned LW       = 8;
    localparam int unsigned LAT_LAST = RD_LAT - 1;

    if (!rd_lat_legal(RD_LAT)) begin : g_rd_lat_check
        $error("memctrl_host: RD_LAT must be 1 or 2");
    end

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] idata_q, rd_data_q;
    logic [LW-1:0] len_q, beat_q;
    logic          we_q;
    logic          lat_q;
    logic          ce_q, csb_q, web_q, oeb_q;
    logic          ce_d, csb_d, web_d, oeb_d;
    logic          rdy_q, rdy_d, wd_ready_q, wd_ready_d;
    logic          done_q, done_d, rd_valid_q, rd_valid_d;
    logic          req_hs, wd_hs, recov_end, last_beat;

    // Ready drops combinationally with BIST so no command slips in during BIST
    assign REQ_READY = rdy_q & ~BIST_BUSY;
    assign req_hs    = REQ_VALID & REQ_READY;
    assign wd_hs     = WD_VALID & wd_ready_q;
    assign recov_end = (state_q == RECOV) && (we_q || (lat_q == 1'(LAT_LAST)));
    assign last_beat = (beat_q == len_q);

    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state, then registered output values derived from the next state
    always_comb begin
        state_d    = state_q;
        ce_d       = CE_IDLE;
        csb_d      = CSB_IDLE;
        web_d      = WEB_IDLE;
        oeb_d      = OEB_IDLE;
        rdy_d      = 1'b0;
        wd_ready_d = 1'b0;
        done_d     = recov_end && last_beat;
        rd_valid_d = recov_end && !we_q;

        case (state_q)
            IDLE:    if (req_hs) state_d = REQ_WE ? WR_WAIT : RD_STB;
            WR_WAIT: if (wd_hs) state_d = WR_STB;
            WR_STB:  state_d = RECOV;
            RD_STB:  state_d = RECOV;
            RECOV: begin
                if (recov_end) begin
                    if (last_beat)      state_d = IDLE;
                    else if (BIST_BUSY) state_d = HOLD;
                    else                state_d = we_q ? WR_WAIT : RD_STB;
                end
            end
            HOLD:    if (!BIST_BUSY) state_d = we_q ? WR_WAIT : RD_STB;
            default: state_d = IDLE;
        endcase

        case (state_d)
            WR_STB: begin
                ce_d  = 1'b1;
                csb_d = 1'b0;
                web_d = 1'b0;
            end
            RD_STB: begin
                ce_d  = 1'b1;
                csb_d = 1'b0;
                oeb_d = 1'b0;
            end
            RECOV:   oeb_d = we_q ? OEB_IDLE : 1'b0;
            WR_WAIT: wd_ready_d = 1'b1;
            // Not ready in the DONE cycle (first IDLE cycle after a burst)
            IDLE:    rdy_d = (state_q == IDLE);
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ce_q       <= CE_IDLE;
            csb_q      <= CSB_IDLE;
            web_q      <= WEB_IDLE;
            oeb_q      <= OEB_IDLE;
            rdy_q      <= 1'b0;
            wd_ready_q <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            ce_q       <= ce_d;
            csb_q      <= csb_d;
            web_q      <= web_d;
            oeb_q      <= oeb_d;
            rdy_q      <= rdy_d;
            wd_ready_q <= wd_ready_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Burst bookkeeping: address, beat count, recovery latency, data capture
    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_q    <= '0;
            idata_q   <= '0;
            rd_data_q <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            we_q      <= 1'b0;
            lat_q     <= 1'b0;
        end else begin
            if (state_q == IDLE && req_hs) begin
                addr_q <= REQ_ADDR;
                len_q  <= REQ_LEN;
                we_q   <= REQ_WE;
                beat_q <= '0;
            end
            if (wd_hs) idata_q <= WD_DATA;
            if (state_q == RD_STB || state_q == WR_STB) lat_q <= 1'b0;
            else if (state_q == RECOV)                  lat_q <= lat_q + 1'b1;
            if (recov_end && !last_beat) begin
                addr_q <= addr_q + AW'(1);
                beat_q <= beat_q + LW'(1);
            end
            if (recov_end && !we_q) rd_data_q <= ODATA;
        end
    end

    assign CE       = ce_q;
    assign CSB      = csb_q;
    assign WEB      = web_q;
    assign OEB      = oeb_q;
    assign ADDR     = addr_q;
    assign IDATA    = idata_q;
    assign RD_DATA  = rd_data_q;
    assign RD_VALID = rd_valid_q;
    assign DONE     = done_q;
    assign WD_READY = wd_ready_q;

endmodule

// File: tb/tb_memctrl_host.sv
// Self-checking bench for memctrl_host: behavioural memory, event logs and a
// burst-level timing/data model derived from the beat rules.
module tb_memctrl_host;

    localparam int unsigned AW     = 16;
    localparam int unsigned DW     = 8;
    localparam int unsigned RD_LAT = 1;

    logic          CLK       = 1'b0;
    logic          RST       = 1'b1;
    logic          REQ_VALID = 1'b0;
    logic          REQ_WE    = 1'b0;
    logic [AW-1:0] REQ_ADDR  = '0;
    logic [7:0]    REQ_LEN   = '0;
    logic          WD_VALID  = 1'b0;
    logic [DW-1:0] WD_DATA   = '0;
    logic          BIST_BUSY = 1'b0;
    logic          REQ_READY, WD_READY, RD_VALID, DONE;
    logic          CE, CSB, WEB, OEB;
    logic [DW-1:0] RD_DATA, IDATA, ODATA;
    logic [AW-1:0] ADDR;

    memctrl_host #(.RD_LAT(RD_LAT), .AW(AW), .DW(DW)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
        .REQ_ADDR(REQ_ADDR), .REQ_LEN(REQ_LEN),
        .WD_VALID(WD_VALID), .WD_READY(WD_READY), .WD_DATA(WD_DATA),
        .RD_VALID(RD_VALID), .RD_DATA(RD_DATA), .DONE(DONE),
        .BIST_BUSY(BIST_BUSY),
        .CE(CE), .CSB(CSB), .WEB(WEB), .OEB(OEB),
        .ADDR(ADDR), .IDATA(IDATA), .ODATA(ODATA)
    );

    always #5 CLK = ~CLK;

    typedef struct { int unsigned cyc; bit we; logic [15:0] addr; logic [7:0] data; } stb_t;
    typedef struct { int unsigned cyc; logic [7:0] data; } rv_t;

    stb_t          stb_log[$];
    rv_t           rv_log[$];
    int unsigned   done_log[$];
    int unsigned   cyc = 0;
    int unsigned   bist_stb = 0, rdy_viol = 0, bad_stb = 0;
    int            n_checks = 0, n_fail = 0;
    logic [7:0]    ref_mem [int];
    logic [7:0]    mem [0:65535];
    bit            wr_flag [0:65535];

    function automatic logic [7:0] dflt(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] exp_rd(input logic [15:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return dflt(a);
    endfunction

    always @(posedge CLK) cyc <= cyc + 1;

    // Behavioural MEMCTRL array: write on strobe, read data valid RD_LAT=1 later
    always @(posedge CLK) begin
        if (CE && !CSB && !WEB) begin
            mem[ADDR]     <= IDATA;
            wr_flag[ADDR] <= 1'b1;
        end
        if (CE && !CSB && !OEB) ODATA <= wr_flag[ADDR] ? mem[ADDR] : dflt(ADDR);
    end

    // Event logger, sampled mid-cycle
    always @(negedge CLK) begin
        stb_t s;
        rv_t  r;
        if (CE && !CSB) begin
            s.cyc = cyc; s.we = !WEB; s.addr = ADDR; s.data = IDATA;
            stb_log.push_back(s);
            if (BIST_BUSY) bist_stb++;
            if (WEB == OEB) bad_stb++;
        end
        if (RD_VALID) begin
            r.cyc = cyc; r.data = RD_DATA;
            rv_log.push_back(r);
        end
        if (DONE) done_log.push_back(cyc);
        if (REQ_READY && (!CSB || WD_READY || RD_VALID || DONE)) rdy_viol++;
    end

    task automatic clear_logs();
        stb_log.delete(); rv_log.delete(); done_log.delete();
    endtask

    task automatic send_cmd(input bit we, input logic [15:0] a, input logic [7:0] len,
                            output int unsigned hs, output bit ok);
        REQ_VALID = 1'b1; REQ_WE = we; REQ_ADDR = a; REQ_LEN = len;
        ok = 1'b0; hs = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (REQ_READY) begin hs = cyc; ok = 1'b1; break; end
        end
        @(posedge CLK); #1;
        REQ_VALID = 1'b0; REQ_ADDR = 16'($urandom); REQ_LEN = 8'($urandom); REQ_WE = 1'($urandom);
    endtask

    task automatic send_wd(input logic [7:0] d, input int unsigned stall,
                           output int unsigned hs, output bit ok);
        WD_VALID = 1'b0;
        repeat (stall) begin @(posedge CLK); #1; end
        WD_VALID = 1'b1; WD_DATA = d;
        ok = 1'b0; hs = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (WD_READY) begin hs = cyc; ok = 1'b1; break; end
        end
        @(posedge CLK); #1;
        WD_VALID = 1'b0; WD_DATA = 8'($urandom);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        n_checks++;
        if ({CE, CSB, WEB, OEB} !== 4'b0111) begin
            n_fail++; $display("FAIL reset_strobes: got %b expected 0111", {CE, CSB, WEB, OEB});
        end
        n_checks++;
        if (ADDR !== 16'h0 || IDATA !== 8'h0 || RD_DATA !== 8'h0) begin
            n_fail++; $display("FAIL reset_data: got addr=%h idata=%h rd_data=%h expected all 0", ADDR, IDATA, RD_DATA);
        end
        n_checks++;
        if ({RD_VALID, DONE, REQ_READY, WD_READY} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 0000", {RD_VALID, DONE, REQ_READY, WD_READY});
        end
        @(posedge CLK); #1; RST = 1'b0;
        @(posedge CLK); @(negedge CLK);
        n_checks++;
        if (REQ_READY !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready: got %b expected 1", REQ_READY);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_write_burst(input logic [15:0] a, input logic [7:0] len,
                                    input int unsigned stall_beat, input int unsigned stall,
                                    input bit fixed, input logic [7:0] fixed_d, input string tag);
        int unsigned hs, d, prev, wstart, exp_d, st;
        int unsigned dcyc[$];
        logic [7:0]  wdat[$];
        logic [7:0]  v;
        logic [15:0] ea;
        bit ok;
        clear_logs();
        send_cmd(1'b1, a, len, hs, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL %s req_timeout: got no REQ_READY expected handshake", tag); return; end
        prev = hs; wstart = hs + 1;
        for (int i = 0; i <= int'(len); i++) begin
            st = (i == int'(stall_beat)) ? stall : 0;
            v  = fixed ? fixed_d : 8'($urandom);
            send_wd(v, st, d, ok);
            exp_d = (wstart > prev + 1 + st) ? wstart : prev + 1 + st;
            n_checks++;
            if (!ok || d !== exp_d) begin
                n_fail++; $display("FAIL %s wd_handshake[%0d]: got ok=%0d cyc=%0d expected cyc=%0d", tag, i, ok, d, exp_d);
                if (!ok) return;
            end
            wdat.push_back(v); dcyc.push_back(d);
            prev = d; wstart = d + 3;
        end
        repeat (6) begin @(posedge CLK); #1; end
        for (int i = 0; i <= int'(len); i++) begin
            ea = 16'(a + 16'(i));
            n_checks++;
            if (i >= stb_log.size()) begin
                n_fail++; $display("FAIL %s wr_strobe[%0d]: got none expected addr=%h", tag, i, ea);
            end else if (stb_log[i].cyc !== dcyc[i] + 1 || stb_log[i].addr !== ea ||
                         stb_log[i].we !== 1'b1 || stb_log[i].data !== wdat[i]) begin
                n_fail++;
                $display("FAIL %s wr_strobe[%0d]: got cyc=%0d addr=%h we=%0d data=%h expected cyc=%0d addr=%h we=1 data=%h",
                         tag, i, stb_log[i].cyc, stb_log[i].addr, stb_log[i].we, stb_log[i].data, dcyc[i] + 1, ea, wdat[i]);
            end
            ref_mem[int'(ea)] = wdat[i];
        end
        n_checks++;
        if (stb_log.size() !== int'(len) + 1 || rv_log.size() !== 0) begin
            n_fail++; $display("FAIL %s wr_counts: got strobes=%0d rd_valid=%0d expected strobes=%0d rd_valid=0",
                               tag, stb_log.size(), rv_log.size(), int'(len) + 1);
        end
        n_checks++;
        if (done_log.size() !== 1 || done_log[0] !== prev + 3) begin
            n_fail++; $display("FAIL %s wr_done: got count=%0d cyc=%0d expected count=1 cyc=%0d",
                               tag, done_log.size(), done_log.size() > 0 ? done_log[0] : 0, prev + 3);
        end
    endtask

    task automatic test_read_burst(input logic [15:0] a, input logic [7:0] len,
                                   input int unsigned b_off, input int unsigned b_len, input string tag);
        int unsigned hs, s, r, b0, b1, exp_done;
        logic [15:0] ea;
        logic [7:0]  ed;
        bit ok;
        clear_logs();
        bist_stb = 0;
        send_cmd(1'b0, a, len, hs, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL %s req_timeout: got no REQ_READY expected handshake", tag); return; end
        b0 = hs + b_off; b1 = b0 + b_len - 1;
        if (b_len > 0) begin
            repeat (b_off - 1) begin @(posedge CLK); #1; end
            BIST_BUSY = 1'b1;
            repeat (b_len) begin @(posedge CLK); #1; end
            BIST_BUSY = 1'b0;
        end
        repeat ((RD_LAT + 1) * (int'(len) + 1) + b_len + 8) begin @(posedge CLK); #1; end
        s = hs + 1; exp_done = 0;
        for (int i = 0; i <= int'(len); i++) begin
            ea = 16'(a + 16'(i));
            ed = exp_rd(ea);
            n_checks++;
            if (i >= stb_log.size()) begin
                n_fail++; $display("FAIL %s rd_strobe[%0d]: got none expected cyc=%0d addr=%h", tag, i, s, ea);
            end else if (stb_log[i].cyc !== s || stb_log[i].addr !== ea || stb_log[i].we !== 1'b0) begin
                n_fail++; $display("FAIL %s rd_strobe[%0d]: got cyc=%0d addr=%h we=%0d expected cyc=%0d addr=%h we=0",
                                   tag, i, stb_log[i].cyc, stb_log[i].addr, stb_log[i].we, s, ea);
            end
            n_checks++;
            if (i >= rv_log.size()) begin
                n_fail++; $display("FAIL %s rd_valid[%0d]: got none expected cyc=%0d data=%h", tag, i, s + RD_LAT + 1, ed);
            end else if (rv_log[i].cyc !== s + RD_LAT + 1 || rv_log[i].data !== ed) begin
                n_fail++; $display("FAIL %s rd_valid[%0d]: got cyc=%0d data=%h expected cyc=%0d data=%h",
                                   tag, i, rv_log[i].cyc, rv_log[i].data, s + RD_LAT + 1, ed);
            end
            r = s + RD_LAT;
            if (i == int'(len))                          exp_done = r + 1;
            else if (b_len > 0 && r >= b0 && r <= b1)    s = b1 + 2;
            else                                         s = r + 1;
        end
        n_checks++;
        if (stb_log.size() !== int'(len) + 1 || rv_log.size() !== int'(len) + 1) begin
            n_fail++; $display("FAIL %s rd_counts: got strobes=%0d rd_valid=%0d expected %0d each",
                               tag, stb_log.size(), rv_log.size(), int'(len) + 1);
        end
        n_checks++;
        if (done_log.size() !== 1 || done_log[0] !== exp_done) begin
            n_fail++; $display("FAIL %s rd_done: got count=%0d cyc=%0d expected count=1 cyc=%0d",
                               tag, done_log.size(), done_log.size() > 0 ? done_log[0] : 0, exp_done);
        end
        if (b_len > 0) begin
            n_checks++;
            if (bist_stb !== 0) begin
                n_fail++; $display("FAIL %s bist_strobes: got %0d expected 0", tag, bist_stb);
            end
        end
    endtask

    task automatic test_bist_idle();
        clear_logs();
        BIST_BUSY = 1'b1; REQ_VALID = 1'b1; REQ_WE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            n_checks++;
            if (REQ_READY !== 1'b0) begin
                n_fail++; $display("FAIL bist_idle_ready[%0d]: got %b expected 0", i, REQ_READY);
            end
        end
        @(posedge CLK); #1;
        REQ_VALID = 1'b0; BIST_BUSY = 1'b0;
        repeat (3) begin @(posedge CLK); #1; end
        @(negedge CLK);
        n_checks++;
        if (REQ_READY !== 1'b1 || stb_log.size() !== 0) begin
            n_fail++; $display("FAIL bist_idle_release: got ready=%b strobes=%0d expected ready=1 strobes=0",
                               REQ_READY, stb_log.size());
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_reset_mid_burst();
        int unsigned hs;
        bit ok;
        clear_logs();
        send_cmd(1'b0, 16'h4321, 8'd3, hs, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rst_mid req_timeout: got no REQ_READY expected handshake"); return; end
        RST = 1'b1;
        @(negedge CLK);
        n_checks++;
        if (CE !== 1'b1 || OEB !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_strobe: got ce=%b oeb=%b expected ce=1 oeb=0", CE, OEB);
        end
        @(negedge CLK);
        n_checks++;
        if ({CE, CSB, WEB, OEB} !== 4'b0111 || REQ_READY !== 1'b0 || WD_READY !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_idle: got strobes=%b ready=%b wd_ready=%b expected 0111 0 0",
                               {CE, CSB, WEB, OEB}, REQ_READY, WD_READY);
        end
        @(posedge CLK); #1; RST = 1'b0;
        @(posedge CLK); @(negedge CLK);
        n_checks++;
        if (REQ_READY !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_ready: got %b expected 1", REQ_READY);
        end
        repeat (4) begin @(posedge CLK); #1; end
        n_checks++;
        if (rv_log.size() !== 0 || done_log.size() !== 0 || stb_log.size() !== 1) begin
            n_fail++; $display("FAIL rst_mid_abandon: got rd_valid=%0d done=%0d strobes=%0d expected 0 0 1",
                               rv_log.size(), done_log.size(), stb_log.size());
        end
    endtask

    task automatic test_back_to_back();
        test_read_burst(16'($urandom), 8'd7, 0, 0, "back_to_back");
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [7:0]  len;
        for (int n = 0; n < 6; n++) begin
            a   = (n % 2 == 0) ? 16'($urandom) : 16'(16'hFFFC + 16'($urandom_range(0, 3)));
            len = 8'($urandom_range(0, 5));
            test_write_burst(a, len, $urandom_range(0, int'(len)), $urandom_range(0, 4), 1'b0, 8'h00, "rnd_write");
            test_read_burst(a, 8'($urandom_range(0, int'(len))), 0, 0, "rnd_read");
        end
    endtask

    task automatic test_protocol();
        n_checks++;
        if (rdy_viol !== 0) begin n_fail++; $display("FAIL ready_while_busy: got %0d cycles expected 0", rdy_viol); end
        n_checks++;
        if (bad_stb !== 0) begin n_fail++; $display("FAIL strobe_encoding: got %0d bad strobes expected 0", bad_stb); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_bist_idle();
        test_write_burst(16'h1234, 8'd0, 0, 0, 1'b1, 8'hA5, "single_write");
        test_read_burst(16'h1234, 8'd0, 0, 0, "single_read");
        test_read_burst(16'hFFFE, 8'd3, 0, 0, "wrap_read");
        test_write_burst(16'h0100, 8'd2, 1, 7, 1'b0, 8'h00, "stall_write");
        test_read_burst(16'h0100, 8'd2, 0, 0, "stall_readback");
        test_read_burst(16'h0200, 8'd3, 4, 10, "bist_read");
        test_back_to_back();
        test_random();
        test_reset_mid_burst();
        test_protocol();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
